// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data ports.
// Define MEM_ARB_RR_EN for a round-robin tie-break; otherwise data wins over fetch.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_data_q, owner_data_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d, i_err_q, i_err_d;
  logic          d_done_q, d_done_d, d_err_q, d_err_d;
  logic          busy_q, busy_d;
  logic          grant_data;

`ifdef MEM_ARB_RR_EN
  logic          prefer_data_q, prefer_data_d;
  // On a tie the port that did not win the previous grant goes next.
  assign grant_data = d_req & (~i_req | prefer_data_q);
`else
  assign grant_data = d_req;
`endif

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    i_err_d      = 1'b0;
    d_done_d     = 1'b0;
    d_err_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
    prefer_data_d = prefer_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          state_d      = ST_ACCESS;
          owner_data_d = grant_data;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = grant_data & d_we;
          mem_addr_d   = grant_data ? d_addr : i_addr;
          if (grant_data) mem_wdata_d = d_wdata;
`ifdef MEM_ARB_RR_EN
          prefer_data_d = ~grant_data;
`endif
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          i_done_d  = ~owner_data_q;
          d_done_d  = owner_data_q;
          if (!mem_we_q) begin
            if (owner_data_q) d_rdata_d = mem_rdata;
            else              i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
          // An ack in the last counted cycle is taken above, so abort only without one.
          if (cnt_inc == CW'(TIMEOUT)) begin
            state_d   = ST_RESP;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            i_done_d  = ~owner_data_q;
            i_err_d   = ~owner_data_q;
            d_done_d  = owner_data_q;
            d_err_d   = owner_data_q;
            if (!mem_we_q) begin
              if (owner_data_q) d_rdata_d = '0;
              else              i_rdata_d = '0;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      owner_data_q <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      i_err_q      <= 1'b0;
      d_done_q     <= 1'b0;
      d_err_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      prefer_data_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      i_err_q      <= i_err_d;
      d_done_q     <= d_done_d;
      d_err_q      <= d_err_d;
      busy_q       <= busy_d;
`ifdef MEM_ARB_RR_EN
      prefer_data_q <= prefer_data_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign i_err     = i_err_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and read data.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESET;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_done, i_err, d_done, d_err, mem_req, mem_we, busy;

  int checks = 0;
  int failures = 0;

  // Model state: expected read-data registers and which port won the last grant.
  logic [DW-1:0] exp_i_rdata, exp_d_rdata;
  logic          last_grant_data;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_data(input logic ir, input logic dr);
    if (ir && dr && RR) return !last_grant_data;
    return dr;
  endfunction

  task automatic test_reset();
    RESET = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 1'b1;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, busy, i_done, d_done, i_err, d_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {mem_req, mem_we, busy, i_done, d_done, i_err, d_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'b0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    RESET = 1'b0; mem_ack = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0; last_grant_data = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic wd;
    logic [DW-1:0] rd;
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h1000; d_addr = 32'h2000;
    for (int g = 0; g < 6; g++) begin
      wd = pick_data(1'b1, 1'b1);
      rd = $urandom;
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== (wd ? d_addr : i_addr)) begin
        failures++;
        $display("FAIL b2b_grant%0d mem_req=%b addr=%h exp_addr=%h", g, mem_req, mem_addr, wd ? d_addr : i_addr);
      end
      mem_ack = 1; mem_rdata = rd;
      tick();
      checks++;
      if ({i_done, d_done} !== (wd ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL b2b_done%0d got i/d=%b%b exp_data_port=%b", g, i_done, d_done, wd);
      end
      if (wd) exp_d_rdata = rd; else exp_i_rdata = rd;
      last_grant_data = wd;
      mem_ack = 0;
      tick();
      checks++;
      if (busy !== 1'b0 || i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
        failures++;
        $display("FAIL b2b_idle%0d busy=%b i_rdata=%h/%h d_rdata=%h/%h", g, busy, i_rdata, exp_i_rdata, d_rdata, exp_d_rdata);
      end
      if (g == 5) begin i_req = 0; d_req = 0; end
    end
    tick();
  endtask

  task automatic test_lone_fetch();
    mem_ack = 0; i_req = 1; i_addr = 32'h100;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || i_done !== 1'b0) begin
      failures++;
      $display("FAIL fetch_access req=%b addr=%h we=%b done=%b exp 1/100/0/0", mem_req, mem_addr, mem_we, i_done);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if (i_done !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'hDEADBEEF || d_done !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done done=%b err=%b rdata=%h d_done=%b req=%b exp 1/0/deadbeef/0/0", i_done, i_err, i_rdata, d_done, mem_req);
    end
    exp_i_rdata = 32'hDEADBEEF; last_grant_data = 1'b0;
    mem_ack = 0; i_req = 0;
    tick();
    checks++;
    if (i_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL fetch_idle done=%b busy=%b exp 0/0", i_done, busy);
    end
  endtask

  task automatic test_store_waits();
    mem_ack = 0; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
    tick();
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678 || d_done !== 1'b0) begin
        failures++;
        $display("FAIL store_access%0d req=%b we=%b addr=%h wdata=%h done=%b", w, mem_req, mem_we, mem_addr, mem_wdata, d_done);
      end
      if (w == 1) begin d_addr = 32'hBAD0; d_wdata = 32'h0; end
      if (w == 3) begin mem_ack = 1; mem_rdata = 32'hCAFEF00D; end
      tick();
    end
    checks++;
    if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== exp_d_rdata || i_done !== 1'b0) begin
      failures++;
      $display("FAIL store_done done=%b err=%b rdata=%h exp 1/0/%h", d_done, d_err, d_rdata, exp_d_rdata);
    end
    last_grant_data = 1'b1;
    mem_ack = 0; d_req = 0; d_we = 0; d_addr = 32'h40;
    tick();
  endtask

  task automatic test_timeout_load();
    mem_ack = 0; d_req = 1; d_we = 0; d_addr = 32'h80;
    tick();
    for (int c = 1; c <= TO; c++) begin
      checks++;
      if (mem_req !== 1'b1 || d_done !== 1'b0) begin
        failures++; $display("FAIL timeout_wait%0d req=%b done=%b exp 1/0", c, mem_req, d_done);
      end
      tick();
    end
    checks++;
    if (d_done !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_done done=%b err=%b rdata=%h req=%b exp 1/1/0/0", d_done, d_err, d_rdata, mem_req);
    end
    exp_d_rdata = '0; last_grant_data = 1'b1; d_req = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || d_done !== 1'b0) begin
      failures++; $display("FAIL timeout_idle busy=%b done=%b exp 0/0", busy, d_done);
    end
  endtask

  task automatic test_random();
    logic wd, acked, we_exp;
    logic [AW-1:0] a_exp;
    logic [DW-1:0] rd;
    int n;
    mem_ack = 0;
    for (int it = 0; it < 40; it++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1; i_addr = $urandom; end
      if (!d_req && ($urandom_range(0, 1) == 1 || !i_req)) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      wd = pick_data(i_req, d_req);
      a_exp = wd ? d_addr : i_addr;
      we_exp = wd & d_we;
      n = $urandom_range(0, TO + 1);
      rd = $urandom;
      acked = 0;
      tick();
      for (int c = 1; c <= TO; c++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== a_exp || mem_we !== we_exp || (we_exp && mem_wdata !== d_wdata) || (i_done | d_done) !== 1'b0) begin
          failures++;
          $display("FAIL rnd_access it%0d c%0d req=%b addr=%h/%h we=%b/%b", it, c, mem_req, mem_addr, a_exp, mem_we, we_exp);
        end
        mem_rdata = $urandom; mem_ack = 0;
        if (n < TO && c == n + 1) begin mem_ack = 1; mem_rdata = rd; acked = 1; end
        tick();
        if (acked) break;
      end
      if (!we_exp) begin
        if (wd) exp_d_rdata = acked ? rd : '0;
        else    exp_i_rdata = acked ? rd : '0;
      end
      checks++;
      if ({i_done, d_done} !== (wd ? 2'b01 : 2'b10) || {i_err, d_err} !== (acked ? 2'b00 : (wd ? 2'b01 : 2'b10))
          || i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata || mem_req !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rnd_resp it%0d done=%b%b err=%b%b i_rdata=%h/%h d_rdata=%h/%h exp_data_port=%b acked=%b",
                 it, i_done, d_done, i_err, d_err, i_rdata, exp_i_rdata, d_rdata, exp_d_rdata, wd, acked);
      end
      last_grant_data = wd;
      if (wd) d_req = 0; else i_req = 0;
      mem_ack = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (busy !== 1'b0 || (i_done | d_done) !== 1'b0 || mem_req !== 1'b0) begin
        failures++; $display("FAIL rnd_idle it%0d busy=%b done=%b%b req=%b", it, busy, i_done, d_done, mem_req);
      end
    end
    i_req = 0; d_req = 0; mem_ack = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    mem_ack = 0; d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rst_mid_access req=%b busy=%b exp 1/1", mem_req, busy);
    end
    RESET = 1; d_req = 0;
    tick();
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || d_done !== 1'b0) begin
      failures++; $display("FAIL rst_mid_abort req=%b busy=%b done=%b exp 0/0/0", mem_req, busy, d_done);
    end
    RESET = 0; mem_ack = 1; mem_rdata = 32'h5555AAAA;
    exp_i_rdata = '0; exp_d_rdata = '0; last_grant_data = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (d_done !== 1'b0 || i_done !== 1'b0 || busy !== 1'b0 || d_rdata !== exp_d_rdata || i_rdata !== exp_i_rdata) begin
        failures++;
        $display("FAIL rst_mid_late_ack%0d done=%b%b busy=%b d_rdata=%h i_rdata=%h exp 0", c, i_done, d_done, busy, d_rdata, i_rdata);
      end
    end
    mem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lone_fetch();
    test_store_waits();
    test_random();
    test_timeout_load();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory between the CPU's instruction-fetch port and its data (load/store) port. Each requester issues a held request; the arbiter grants one at a time, drives the memory handshake, and returns a one-cycle completion pulse with registered read data. A bounded wait counter turns a missing memory acknowledge into an error response instead of a hang. It sits between the CPU top level and the shared memory model/controller.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, cycles in ACCESS without `mem_ack` before abort (must be ≥1)
- `clk`  in  1  clock, rising edge
- `RESET`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request, held until `i_done`
- `i_addr`  in  AW  fetch address
- `i_rdata`  out  DW  fetched word, valid with `i_done`, held until next fetch completion
- `i_done`  out  1  one-cycle fetch completion pulse
- `i_err`  out  1  with `i_done`: fetch aborted by timeout
- `d_req`  in  1  data request, held until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data, valid with `d_done`, held until next load completion
- `d_done`  out  1  one-cycle data completion pulse
- `d_err`  out  1  with `d_done`: access aborted by timeout
- `mem_req`  out  1  memory request, held until ack or abort
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, sampled only while `mem_req`=1
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any `*_req`=1, select winner, latch its addr/we/wdata into mem registers (fetch forces `mem_we`=0), record owner, clear wait counter, → ACCESS. Else stay.
- Winner (default): data port wins when both request.
- ACCESS: `mem_req`=1, mem fields constant. `mem_ack`=1 → capture `mem_rdata` if read, → RESP. Else counter+1; counter reaching `TIMEOUT` → RESP with error flag.
- RESP: `mem_req`=0; owner's `*_done`=1; owner's `*_err`=error flag; → IDLE.
- Read data: owner's `*_rdata` loads `mem_rdata` on acked read; loads 0 on aborted read; unchanged on store (acked or aborted).
- Requester contract: req and fields stable from assertion until done; req deasserted at the edge that samples done. Req still high in IDLE after RESP is a new request.
- Fields changed after grant are ignored (latched copy used).
- `mem_ack` in IDLE or RESP: ignored.
- Requester dropping req mid-ACCESS: access still completes; done still pulses.

## Timing
- Reset (synchronous, priority over all): state IDLE; `mem_req`, `mem_we`, `*_done`, `*_err`, `busy` = 0; `mem_addr`, `mem_wdata`, `*_rdata` = 0; counter 0; round-robin pointer → data-first. Reset during ACCESS aborts with no done pulse.
- Req sampled high at edge k (IDLE) → `mem_req`=1 from cycle k+1.
- Zero-wait memory: `mem_ack`=1 in cycle k+1 → `*_done` in cycle k+2. Minimum 3 cycles per access, back-to-back throughput one access per 3 cycles.
- N wait cycles: done at k+2+N.
- Timeout: ack absent for `TIMEOUT` ACCESS cycles → done+err in cycle k+1+`TIMEOUT`. Ack in the final counted cycle wins over timeout.
- All outputs registered; no combinational input→output path.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break — when both request in IDLE, the port not granted last wins; pointer updates at every grant.
- Undefined: fixed priority, data over fetch; no pointer state.
- Single-requester behaviour identical either way.

## Test plan
- Lone fetch, `i_addr`=0x100, ack in first ACCESS cycle with rdata 0xDEADBEEF → `mem_req` cycle k+1, `i_done`=1 cycle k+2, `i_rdata`=0xDEADBEEF, `i_err`=0.
- Store `d_addr`=0x40, `d_wdata`=0x12345678, ack after 3 waits → `mem_we`=1 throughout ACCESS, `d_done` at k+5, `d_rdata` unchanged.
- Both req held continuously, zero-wait memory → fixed build: D,D,D…; `MEM_ARB_RR_EN`: D,I,D,I alternating, one grant per 3 cycles.
- `TIMEOUT`=4, no ack on load → `mem_req` high 4 cycles, `d_done`=1 and `d_err`=1 at k+5, `d_rdata`=0, back to IDLE.
- `RESET` asserted in second ACCESS cycle → next cycle `mem_req`=0, `busy`=0, no done pulse; late `mem_ack` ignored.
- `d_addr` changed mid-ACCESS → `mem_addr` keeps granted value until completion.
